// File: rtl/xbus_arbiter.sv
// xbus_arbiter: pairs one blocked XBus writer with one blocked reader per transfer,
// round-robin on both sides, and pulses wr_ack/rd_ack for a single cycle.
module xbus_arbiter #(
   parameter int DATA_W  = 11,
   parameter int N_PORTS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_PORTS-1:0]         wr_req,
   input  logic [N_PORTS*DATA_W-1:0]  wr_dat,
   input  logic [N_PORTS-1:0]         rd_req,
   output logic [N_PORTS-1:0]         wr_ack,
   output logic [N_PORTS-1:0]         rd_ack,
   output logic [DATA_W-1:0]          rd_dat,
   output logic                       bus_pend
);
   localparam int PW = $clog2(N_PORTS);
   localparam logic [N_PORTS-1:0] ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

   state_t               state, state_nx;
   logic [PW-1:0]        wr_ptr, rd_ptr, w_sel, r_sel, w_nx, r_nx, wi, ri;
   logic                 found, grant;
   logic [N_PORTS-1:0]   wr_ack_nx, rd_ack_nx;
   logic [DATA_W-1:0]    rd_dat_nx;
   logic                 bus_pend_nx;

   function automatic logic [PW-1:0] wrap(input int a);
      return PW'(a >= N_PORTS ? a - N_PORTS : a);
   endfunction

   // first writer (from wr_ptr) that has a reader other than itself (from rd_ptr)
   always_comb begin
      found = 1'b0;
      w_nx  = w_sel;
      r_nx  = r_sel;
      wi    = '0;
      ri    = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         wi = wrap(int'(wr_ptr) + k);
         for (int j = 0; j < N_PORTS; j++) begin
            ri = wrap(int'(rd_ptr) + j);
            if (!found && wr_req[wi] && rd_req[ri] && ri != wi) begin
               found = 1'b1;
               w_nx  = wi;
               r_nx  = ri;
            end
         end
      end
   end

   // leaving HOLD re-arbitrates on the same edge so back-to-back grants are two cycles apart
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = found ? XFER : IDLE;
         XFER:    state_nx = HOLD;
         HOLD:    state_nx = (!wr_req[w_sel] && !rd_req[r_sel]) ? (found ? XFER : IDLE) : HOLD;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      grant       = state_nx == XFER;
      wr_ack_nx   = grant ? ONE << w_nx : '0;
      rd_ack_nx   = grant ? ONE << r_nx : '0;
      rd_dat_nx   = grant ? wr_dat[int'(w_nx)*DATA_W +: DATA_W] : '0;
      bus_pend_nx = state_nx == IDLE && |wr_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         w_sel    <= '0;
         r_sel    <= '0;
         wr_ack   <= '0;
         rd_ack   <= '0;
         rd_dat   <= '0;
         bus_pend <= 1'b0;
      end else begin
         state    <= state_nx;
         wr_ack   <= wr_ack_nx;
         rd_ack   <= rd_ack_nx;
         rd_dat   <= rd_dat_nx;
         bus_pend <= bus_pend_nx;
         if (grant) begin
            w_sel <= w_nx;
            r_sel <= r_nx;
         end
         if (state == XFER) begin
            wr_ptr <= wrap(int'(w_sel) + 1);
            rd_ptr <= wrap(int'(r_sel) + 1);
         end
      end
   end
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed vectors for xbus_arbiter with hand-computed expectations.
module tb_xbus_arbiter;
   localparam int DW = 11;
   localparam int NP = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    wr_req = '0, rd_req = '0, wr_ack, rd_ack;
   logic [NP*DW-1:0] wr_dat = '0;
   logic [DW-1:0]    rd_dat;
   logic             bus_pend;
   int               n_cmp = 0, n_bad = 0;

   xbus_arbiter #(.DATA_W(DW), .N_PORTS(NP)) dut (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_dat(wr_dat), .rd_req(rd_req),
      .wr_ack(wr_ack), .rd_ack(rd_ack), .rd_dat(rd_dat), .bus_pend(bus_pend)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic acks(input string tag, input logic [NP-1:0] w, input logic [NP-1:0] r, input logic [DW-1:0] d);
      check({tag, ".wr_ack"}, 32'(wr_ack), 32'(w));
      check({tag, ".rd_ack"}, 32'(rd_ack), 32'(r));
      check({tag, ".rd_dat"}, 32'(rd_dat), 32'(d));
   endtask

   task automatic set_dat(input int i, input int v);
      wr_dat[i*DW +: DW] = DW'(v);
   endtask

   task automatic do_reset();
      wr_req = '0;
      rd_req = '0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n  = 1'b1;
   endtask

   initial begin
      // reset state
      tick();
      acks("rst", 4'b0000, 4'b0000, 11'd0);
      check("rst.bus_pend", 32'(bus_pend), 32'd0);
      // 1: basic transfer 0 -> 2
      do_reset();
      set_dat(0, 37);
      wr_req = 4'b0001;
      rd_req = 4'b0100;
      tick();
      acks("t1.xfer", 4'b0001, 4'b0100, 11'd37);
      wr_req = '0;
      rd_req = '0;
      tick();
      acks("t1.hold", 4'b0000, 4'b0000, 11'd0);
      tick();
      // 2: lone writer waits, bus_pend raised
      do_reset();
      set_dat(1, -5);
      wr_req = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0 || i == 9) begin
            acks("t2.wait", 4'b0000, 4'b0000, 11'd0);
            check("t2.bus_pend", 32'(bus_pend), 32'd1);
         end
      end
      rd_req = 4'b1000;
      tick();
      acks("t2.xfer", 4'b0010, 4'b1000, 11'h7FB);
      wr_req = '0;
      rd_req = '0;
      tick();
      tick();
      // 3: four writers, reader 3 re-raised; writer 3 skipped, then pointer wrap
      do_reset();
      for (int i = 0; i < 4; i++) set_dat(i, 10 * (i + 1));
      wr_req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         rd_req = 4'b1000;
         tick();
         acks($sformatf("t3.xfer%0d", i), 4'(1 << i), 4'b1000, 11'(10 * (i + 1)));
         wr_req[i] = 1'b0;
         rd_req    = '0;
         tick();
         acks($sformatf("t3.hold%0d", i), 4'b0000, 4'b0000, 11'd0);
         tick();
      end
      rd_req = 4'b1000;
      tick();
      tick();
      acks("t3.self3", 4'b0000, 4'b0000, 11'd0);
      rd_req = 4'b1001;
      tick();
      acks("t3.w3r0", 4'b1000, 4'b0001, 11'd40);
      wr_req = '0;
      rd_req = '0;
      tick();
      tick();
      wr_req = 4'b0011;
      rd_req = 4'b0100;
      tick();
      acks("t3.wrap", 4'b0001, 4'b0100, 11'd10);
      wr_req = '0;
      rd_req = '0;
      tick();
      tick();
      // 4: self pair never granted
      do_reset();
      wr_req = 4'b0100;
      rd_req = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i % 5 == 4) acks($sformatf("t4.self%0d", i), 4'b0000, 4'b0000, 11'd0);
      end
      // 5: requesters held through HOLD
      do_reset();
      set_dat(0, 5);
      wr_req = 4'b0001;
      rd_req = 4'b0010;
      tick();
      acks("t5.xfer", 4'b0001, 4'b0010, 11'd5);
      for (int i = 0; i < 5; i++) begin
         tick();
         acks($sformatf("t5.hold%0d", i), 4'b0000, 4'b0000, 11'd0);
      end
      wr_req = '0;
      rd_req = '0;
      tick();
      acks("t5.rel", 4'b0000, 4'b0000, 11'd0);
      set_dat(2, 7);
      wr_req = 4'b0100;
      rd_req = 4'b1000;
      tick();
      acks("t5.next", 4'b0100, 4'b1000, 11'd7);
      wr_req = '0;
      rd_req = '0;
      tick();
      tick();
      // 6: reset during XFER, then repeat
      do_reset();
      set_dat(0, 99);
      wr_req = 4'b0001;
      rd_req = 4'b0010;
      tick();
      acks("t6.xfer", 4'b0001, 4'b0010, 11'd99);
      #2 rst_n = 1'b0;
      #1 acks("t6.rst", 4'b0000, 4'b0000, 11'd0);
      #2 rst_n = 1'b1;
      tick();
      acks("t6.again", 4'b0001, 4'b0010, 11'd99);
      wr_req = '0;
      rd_req = '0;
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
